// File: rtl/nios_system_encoder_r.sv
// nios_system_encoder_r
// Avalon-MM slave quadrature-encoder reader for the right motor.
// Synchronises the asynchronous A/B channels, decodes x4 quadrature into a
// signed 16-bit position, flags position wrap and illegal (double-bit)
// transitions, and raises a level interrupt on enabled status events.
//
// Optional feature macro: ENCODER_SPEED_EN
//   When defined, a window counter of WINDOW_CYCLES clocks measures the
//   number of counts per window (saturating) and publishes it in SPEED,
//   setting STATUS.WIN at each window end. When undefined, SPEED and
//   STATUS[2] read 0 and no window logic exists.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   address    register select (0 POSITION, 1 CONTROL, 2 STATUS, 3 SPEED)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data, zero wait states
//   enc_a      encoder channel A (asynchronous)
//   enc_b      encoder channel B (asynchronous)
//   irq        active-high level interrupt
module nios_system_encoder_r #(
    parameter int WINDOW_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        enc_a,
    input  logic        enc_b,
    output logic        irq
);

    localparam logic [1:0] ADDR_POS    = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_SPEED  = 2'd3;

    // Position along the forward Gray sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_idx(input logic [1:0] s);
        logic [1:0] idx;
        case (s)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            2'b01:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Signed 16-bit add clamped to +32767 / -32768.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        logic [15:0] res;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
            res = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            res = sum[15:0];
        end
        return res;
    endfunction

    logic [1:0]  sync1_r;
    logic [1:0]  sync2_r;
    logic [1:0]  prev_r;
    logic [15:0] pos_r;
    logic [2:0]  ctrl_r;
    logic [2:0]  status_r;
    logic        irq_r;

    logic        wr_s;
    logic        pos_wr_s;
    logic        ctrl_wr_s;
    logic        stat_wr_s;
    logic [1:0]  step_s;
    logic [15:0] raw_delta_s;
    logic [15:0] dir_delta_s;
    logic [15:0] delta_s;
    logic        illegal_s;
    logic        err_set_s;
    logic        wrap_set_s;
    logic        win_set_s;
    logic [15:0] pos_next_s;
    logic [2:0]  ctrl_next_s;
    logic [2:0]  status_next_s;
    logic        irq_next_s;
    logic [15:0] speed_rd_s;
    logic        unused_s;

    assign wr_s      = chipselect & ~write_n;
    assign pos_wr_s  = wr_s & (address == ADDR_POS);
    assign ctrl_wr_s = wr_s & (address == ADDR_CTRL);
    assign stat_wr_s = wr_s & (address == ADDR_STATUS);
    assign unused_s  = (^writedata[31:16]) ^ (WINDOW_CYCLES < 2);

    // Quadrature decode of prev -> current synchronised sample, gated by EN/INV.
    always_comb begin
        raw_delta_s = 16'h0000;
        illegal_s   = 1'b0;
        step_s      = gray_idx(sync2_r) - gray_idx(prev_r);
        case (step_s)
            2'd1:    raw_delta_s = 16'h0001;
            2'd3:    raw_delta_s = 16'hFFFF;
            2'd2:    illegal_s   = 1'b1;
            default: raw_delta_s = 16'h0000;
        endcase
        if (ctrl_r[1]) begin
            dir_delta_s = 16'h0000 - raw_delta_s;
        end else begin
            dir_delta_s = raw_delta_s;
        end
        if (ctrl_r[0]) begin
            delta_s   = dir_delta_s;
            err_set_s = illegal_s;
        end else begin
            delta_s   = 16'h0000;
            err_set_s = 1'b0;
        end
    end

    // Next position / control / status / irq; a bus write to POSITION drops
    // the concurrent count, and status sets beat same-cycle W1C clears.
    always_comb begin
        wrap_set_s = 1'b0;
        if (pos_wr_s) begin
            pos_next_s = writedata[15:0];
        end else begin
            pos_next_s = pos_r + delta_s;
            wrap_set_s = ((pos_r == 16'h7FFF) && (delta_s == 16'h0001)) ||
                         ((pos_r == 16'h8000) && (delta_s == 16'hFFFF));
        end
        if (ctrl_wr_s) begin
            ctrl_next_s = writedata[2:0];
        end else begin
            ctrl_next_s = ctrl_r;
        end
        if (stat_wr_s) begin
            status_next_s = status_r & ~writedata[2:0];
        end else begin
            status_next_s = status_r;
        end
        status_next_s = status_next_s | {win_set_s, err_set_s, wrap_set_s};
        irq_next_s    = ctrl_next_s[2] & (|status_next_s);
    end

    // Synchroniser, decode history and architectural registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            prev_r   <= 2'b00;
            pos_r    <= 16'h0000;
            ctrl_r   <= 3'b000;
            status_r <= 3'b000;
            irq_r    <= 1'b0;
        end else begin
            sync1_r  <= {enc_a, enc_b};
            sync2_r  <= sync1_r;
            prev_r   <= sync2_r;
            pos_r    <= pos_next_s;
            ctrl_r   <= ctrl_next_s;
            status_r <= status_next_s;
            irq_r    <= irq_next_s;
        end
    end

`ifdef ENCODER_SPEED_EN
    logic [31:0] win_cnt_r;
    logic [15:0] acc_r;
    logic [15:0] speed_r;
    logic        win_term_s;
    logic [15:0] acc_sum_s;

    assign win_term_s = ctrl_r[0] && (win_cnt_r == 32'(WINDOW_CYCLES - 1));
    assign acc_sum_s  = sat_add16(acc_r, delta_s);
    assign win_set_s  = win_term_s;
    assign speed_rd_s = speed_r;

    // Window counter and saturating count accumulator for speed measurement.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_cnt_r <= 32'd0;
            acc_r     <= 16'h0000;
            speed_r   <= 16'h0000;
        end else if (!ctrl_r[0]) begin
            win_cnt_r <= 32'd0;
        end else if (win_term_s) begin
            win_cnt_r <= 32'd0;
            acc_r     <= 16'h0000;
            speed_r   <= acc_sum_s;
        end else begin
            win_cnt_r <= win_cnt_r + 32'd1;
            acc_r     <= acc_sum_s;
        end
    end
`else
    assign win_set_s  = 1'b0;
    assign speed_rd_s = 16'h0000;
`endif

    // Zero-wait-state read mux.
    always_comb begin
        case (address)
            ADDR_POS:    readdata = {{16{pos_r[15]}}, pos_r};
            ADDR_CTRL:   readdata = {29'd0, ctrl_r};
            ADDR_STATUS: readdata = {29'd0, status_r};
            ADDR_SPEED:  readdata = {{16{speed_rd_s[15]}}, speed_rd_s};
            default:     readdata = 32'd0;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_nios_system_encoder_r.sv
module tb_nios_system_encoder_r;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        enc_a;
    logic        enc_b;
    logic        irq;

    int checks;
    int errors;
    logic [1:0]  enc_s;
    logic [31:0] rd;
    logic [31:0] stat_mask;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] init_pos;
        int          steps;
        logic [31:0] exp_pos;
        logic [31:0] exp_status;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[8];

    nios_system_encoder_r #(.WINDOW_CYCLES(100)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_enc(input logic [1:0] s, input int hold);
        enc_s = s;
        {enc_a, enc_b} = s;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic move(input int steps, input int hold);
        if (steps >= 0) begin
            for (int i = 0; i < steps; i++) set_enc(fwd(enc_s), hold);
        end else begin
            for (int i = 0; i < -steps; i++) set_enc(rev(enc_s), hold);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        bus_read(2'd0, rd); check({tag, " pos"}, rd, 32'h0);
        bus_read(2'd1, rd); check({tag, " ctrl"}, rd, 32'h0);
        bus_read(2'd2, rd); check({tag, " status"}, rd, 32'h0);
        bus_read(2'd3, rd); check({tag, " speed"}, rd, 32'h0);
        check({tag, " irq"}, {31'd0, irq}, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        address = 2'd0;
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = 32'd0;
        enc_s = 2'b00;
        {enc_a, enc_b} = 2'b00;
`ifdef ENCODER_SPEED_EN
        stat_mask = 32'h3;
`else
        stat_mask = 32'hFFFF_FFFF;
`endif

        //             ctrl   init_pos       steps  exp_pos        exp_status irq
        vecs[0] = '{32'h1, 32'h0000_0000,  8, 32'h0000_0008, 32'h0, 1'b0};
        vecs[1] = '{32'h3, 32'h0000_0000,  8, 32'hFFFF_FFF8, 32'h0, 1'b0};
        vecs[2] = '{32'h5, 32'h0000_7FFF,  1, 32'hFFFF_8000, 32'h1, 1'b1};
        vecs[3] = '{32'h1, 32'h0000_0000, -3, 32'hFFFF_FFFD, 32'h0, 1'b0};
        vecs[4] = '{32'h5, 32'h0000_8000, -1, 32'h0000_7FFF, 32'h1, 1'b1};
        vecs[5] = '{32'h0, 32'h0000_0064,  5, 32'h0000_0064, 32'h0, 1'b0};
        vecs[6] = '{32'h3, 32'h0000_000A, -4, 32'h0000_000E, 32'h0, 1'b0};
        vecs[7] = '{32'h1, 32'h0000_7FFF,  2, 32'hFFFF_8001, 32'h1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reset_state("reset");

        for (int v = 0; v < 8; v++) begin
            bus_write(2'd2, 32'h7);
            bus_write(2'd1, vecs[v].ctrl);
            bus_write(2'd0, vecs[v].init_pos);
            move(vecs[v].steps, 10);
            bus_read(2'd0, rd);
            check($sformatf("vec%0d pos", v), rd, vecs[v].exp_pos);
            bus_read(2'd2, rd);
            check($sformatf("vec%0d status", v), rd & stat_mask, vecs[v].exp_status);
            check($sformatf("vec%0d irq", v), {31'd0, irq}, {31'd0, vecs[v].exp_irq});
        end

        // Control reads back only its three defined bits.
        bus_write(2'd1, 32'hFFFF_FFFE);
        bus_read(2'd1, rd);
        check("ctrl readback", rd, 32'h6);

        // WRAP pending with IRQ_EN and EN=0; clear only WRAP drops irq.
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, rd);
        check("w1c pre status", rd, 32'h1);
        check("w1c pre irq", {31'd0, irq}, 32'h1);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd);
        check("w1c status", rd, 32'h0);
        check("w1c irq", {31'd0, irq}, 32'h0);
`ifndef ENCODER_SPEED_EN
        bus_read(2'd3, rd);
        check("speed no macro", rd, 32'h0);
`endif

        // Illegal jump with EN=1: no count, ERR; then WRAP; partial W1C.
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h7);
        bus_write(2'd0, 32'h0000_0123);
        set_enc(~enc_s, 10);
        bus_read(2'd0, rd);
        check("illegal pos", rd, 32'h0000_0123);
        bus_read(2'd2, rd);
        check("illegal err", rd & stat_mask, 32'h2);
        bus_write(2'd0, 32'h0000_7FFF);
        move(1, 10);
        bus_read(2'd2, rd);
        check("err+wrap", rd & stat_mask, 32'h3);
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, rd);
        check("partial w1c", rd & stat_mask, 32'h1);

        // Illegal jump with EN=0 sets nothing.
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h7);
        bus_write(2'd0, 32'h0000_0123);
        set_enc(~enc_s, 10);
        bus_read(2'd2, rd);
        check("illegal en0 status", rd, 32'h0);
        bus_read(2'd0, rd);
        check("illegal en0 pos", rd, 32'h0000_0123);

        // POSITION write lands on the same edge as a decoded count.
        bus_write(2'd1, 32'h1);
        bus_write(2'd0, 32'h0);
        set_enc(fwd(enc_s), 2);
        bus_write(2'd0, 32'h5);
        repeat (10) @(posedge clk);
        #1;
        bus_read(2'd0, rd);
        check("write wins", rd, 32'h5);

        // Reset in the middle of motion with status/irq active.
        bus_write(2'd1, 32'h5);
        set_enc(~enc_s, 5);
        check("pre reset irq", {31'd0, irq}, 32'h1);
        set_enc(fwd(enc_s), 1);
        do_reset();
        check_reset_state("mid reset");

`ifdef ENCODER_SPEED_EN
        repeat (5) @(posedge clk);
        #1;
        bus_write(2'd1, 32'h1);
        move(20, 4);
        repeat (19) @(posedge clk);
        #1;
        bus_read(2'd2, rd);
        check("win before end", rd & 32'h4, 32'h0);
        @(posedge clk);
        #1;
        bus_read(2'd2, rd);
        check("win at end", rd & 32'h4, 32'h4);
        bus_read(2'd3, rd);
        check("speed 20", rd, 32'd20);
        bus_write(2'd2, 32'h4);
        repeat (99) @(posedge clk);
        #1;
        bus_read(2'd3, rd);
        check("speed idle", rd, 32'd0);
        bus_read(2'd2, rd);
        check("win second", rd & 32'h4, 32'h4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
